sram_port0_arbiter: RTL and testbench

- Shares the 1RW port (port 0) of one 32x512 OpenRAM SRAM macro between two requesters: req0 (Wishbone-side host) and req1 (core).
- Round-robin arbitration with valid/ready handshakes; at most one access issued per cycle.
- Each response is routed back to its originating requester with fixed latency.
- Optional post-reset clear sequencer zero-fills the whole array before any requester is served. Port 1 (read-only) is not handled by this block.

---
 rtl/sram_port0_arbiter_pkg.sv | 27 ++
 rtl/sram_port0_arbiter_rr_arbiter2.sv | 31 +++
 rtl/sram_port0_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port0_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_ctrl_pkg : shared types and defaults for the SRAM port control   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sram_ctrl_pkg;

    localparam int ADDR_WIDTH_DFLT = 9;
    localparam int DATA_WIDTH_DFLT = 32;
    localparam int NUM_WMASKS_DFLT = DATA_WIDTH_DFLT / 8;

    // Accept cycle -> response strobe cycle is exactly this many stages.
    localparam int RSP_PIPE_DEPTH = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
        logic is_read;
    } rsp_pipe_t;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_port0_arbiter_rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin arbiter, one-hot grant              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       update_o,
    output logic       next_last_o
);

    // last_grant_i = 1 means requester 1 won last time, so requester 0 wins a tie.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i[0] && (!valid_i[1] || last_grant_i)) begin
                grant_o = 2'b01;
            end else if (valid_i[1]) begin
                grant_o = 2'b10;
            end
        end
    end

    assign update_o    = |grant_o;
    assign next_last_o = grant_o[1];

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/sram_port0_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_port0_arbiter : round-robin sharing of SRAM port 0 with clear    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sram_port0_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DFLT,
    parameter int NUM_WMASKS     = NUM_WMASKS_DFLT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    arb_state_e                          state_q, state_d;
    logic [ADDR_WIDTH:0]                 clr_cnt_q, clr_cnt_d;
    logic                                last_q, last_d;
    rsp_pipe_t [RSP_PIPE_DEPTH-1:0]      pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0]               rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]               rdata1_q, rdata1_d;

    logic                                run_en;
    logic [1:0]                          grant;
    logic                                arb_update;
    logic                                arb_next_last;

    logic                                sel_we;
    logic [NUM_WMASKS-1:0]               sel_wmask;
    logic [ADDR_WIDTH-1:0]               sel_addr;
    logic [DATA_WIDTH-1:0]               sel_wdata;

    assign run_en = (state_q == ST_RUN) && !wb_rst_i;

    rr_arbiter2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_q),
        .enable_i     (run_en),
        .grant_o      (grant),
        .update_o     (arb_update),
        .next_last_o  (arb_next_last)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        if (grant[1]) begin
            sel_we    = req1_we;
            sel_wmask = req1_wmask;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end else begin
            sel_we    = req0_we;
            sel_wmask = req0_wmask;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end
    end

    // Macro pins are driven in the accept cycle so the macro samples them on
    // the same edge that completes the handshake.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (!wb_rst_i) begin
            if (state_q == ST_INIT) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = clr_cnt_q[ADDR_WIDTH-1:0];
            end else if (|grant) begin
                sram_csb0  = 1'b0;
                sram_web0  = !sel_we;
                sram_addr0 = sel_addr;
                if (sel_we) begin
                    sram_wmask0 = sel_wmask;
                    sram_din0   = sel_wdata;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        last_d    = last_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        // The counter MSB marks the write of the last address; no wrap to 0 is issued.
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + (ADDR_WIDTH+1)'(1);
            if (clr_cnt_d[ADDR_WIDTH]) begin
                state_d = ST_RUN;
            end
        end

        if (arb_update) begin
            last_d = arb_next_last;
        end

        pipe_d[0].valid   = arb_update;
        pipe_d[0].id      = grant[1];
        pipe_d[0].is_read = arb_update && !sel_we;
        pipe_d[1]         = pipe_q[0];

        if (pipe_q[0].valid) begin
            if (pipe_q[0].id) begin
                rdata1_d = pipe_q[0].is_read ? sram_dout0 : '0;
            end else begin
                rdata0_d = pipe_q[0].is_read ? sram_dout0 : '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            clr_cnt_q <= '0;
            last_q    <= 1'b1;
            pipe_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            last_q    <= last_d;
            pipe_q    <= pipe_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rsp0_valid = pipe_q[RSP_PIPE_DEPTH-1].valid && !pipe_q[RSP_PIPE_DEPTH-1].id;
    assign rsp1_valid = pipe_q[RSP_PIPE_DEPTH-1].valid &&  pipe_q[RSP_PIPE_DEPTH-1].id;
    assign rsp0_rdata = rdata0_q;
    assign rsp1_rdata = rdata1_q;

    // Held low through reset so no requester sees a ready window early.
    assign init_done = (state_q == ST_RUN) && !wb_rst_i;

endmodule : sram_port0_arbiter
`default_nettype wire

// File: tb/tb_sram_port0_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_port0_arbiter : directed bench with reference model and SRAM  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sram_port0_arbiter;

    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [3:0]  req0_wmask = '0;
    logic [8:0]  req0_addr  = '0;
    logic [31:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [3:0]  req1_wmask = '0;
    logic [8:0]  req1_addr  = '0;
    logic [31:0] req1_wdata = '0;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0;

    sram_port0_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Second instance without the clear sequence; req0 requests permanently.
    logic        nc_req0_ready, nc_req1_ready, nc_rsp0_valid, nc_rsp1_valid, nc_init_done;
    logic [31:0] nc_rsp0_rdata, nc_rsp1_rdata, nc_sram_din0;
    logic        nc_sram_csb0, nc_sram_web0;
    logic [3:0]  nc_sram_wmask0;
    logic [8:0]  nc_sram_addr0;

    sram_port0_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nc (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(1'b1), .req0_ready(nc_req0_ready), .req0_we(1'b0),
        .req0_wmask(4'h0), .req0_addr(9'h000), .req0_wdata(32'h0),
        .req1_valid(1'b0), .req1_ready(nc_req1_ready), .req1_we(1'b0),
        .req1_wmask(4'h0), .req1_addr(9'h000), .req1_wdata(32'h0),
        .rsp0_valid(nc_rsp0_valid), .rsp0_rdata(nc_rsp0_rdata),
        .rsp1_valid(nc_rsp1_valid), .rsp1_rdata(nc_rsp1_rdata),
        .init_done(nc_init_done),
        .sram_csb0(nc_sram_csb0), .sram_web0(nc_sram_web0), .sram_wmask0(nc_sram_wmask0),
        .sram_addr0(nc_sram_addr0), .sram_din0(nc_sram_din0), .sram_dout0(32'h0)
    );

    // SRAM macro: pins latched on posedge, array written / read on the following negedge.
    logic [31:0] sram_mem [DEPTH];
    logic        l_csb = 1'b1, l_web = 1'b1;
    logic [3:0]  l_wm;
    logic [8:0]  l_a;
    logic [31:0] l_d;

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
    end

    always @(posedge clk) begin
        l_csb <= sram_csb0;
        l_web <= sram_web0;
        l_wm  <= sram_wmask0;
        l_a   <= sram_addr0;
        l_d   <= sram_din0;
    end

    always @(negedge clk) begin
        if (l_csb == 1'b0) begin
            if (l_web == 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (l_wm[b]) sram_mem[l_a][8*b +: 8] = l_d[8*b +: 8];
            end else begin
                sram_dout0 <= sram_mem[l_a];
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an ideal memory plus a queue of responses due at given cycles.
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } exp_t;

    exp_t        pq[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata [2];
    int          m_init_left = 0;
    bit          m_last = 1'b1;
    bit          armed = 1'b0;

    task automatic rsp_check();
        bit ev0, ev1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        while (pq.size() > 0 && pq[0].due == cyc) begin
            if (pq[0].id) ev1 = 1'b1; else ev0 = 1'b1;
            m_rdata[pq[0].id] = pq[0].data;
            void'(pq.pop_front());
        end
        chk("rsp0_valid", rsp0_valid, ev0);
        chk("rsp1_valid", rsp1_valid, ev1);
        chk("rsp0_rdata", rsp0_rdata, m_rdata[0]);
        chk("rsp1_rdata", rsp1_rdata, m_rdata[1]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (armed) begin
                    chk("rst_ready0", req0_ready, 0);
                    chk("rst_ready1", req1_ready, 0);
                    chk("rst_csb", sram_csb0, 1);
                    chk("rst_web", sram_web0, 1);
                    chk("rst_init_done", init_done, 0);
                    rsp_check();
                end
                pq.delete();
                m_init_left = DEPTH;
                m_last      = 1'b1;
                m_rdata[0]  = '0;
                m_rdata[1]  = '0;
                armed       = 1'b1;
            end else if (armed) begin
                if (m_init_left > 0) begin
                    chk("init_ready0", req0_ready, 0);
                    chk("init_ready1", req1_ready, 0);
                    chk("init_done_low", init_done, 0);
                    chk("init_csb", sram_csb0, 0);
                    chk("init_web", sram_web0, 0);
                    chk("init_wmask", sram_wmask0, 4'hF);
                    chk("init_addr", sram_addr0, DEPTH - m_init_left);
                    chk("init_din", sram_din0, 0);
                    m_mem[DEPTH - m_init_left] = '0;
                    m_init_left--;
                end else begin
                    bit g0, g1, we;
                    logic [3:0]  mk;
                    logic [8:0]  ad;
                    logic [31:0] wd;
                    exp_t e;
                    g0 = req0_valid && (!req1_valid || m_last);
                    g1 = req1_valid && !g0;
                    chk("run_init_done", init_done, 1);
                    chk("ready0", req0_ready, g0);
                    chk("ready1", req1_ready, g1);
                    if (g0 || g1) begin
                        we = g1 ? req1_we    : req0_we;
                        mk = g1 ? req1_wmask : req0_wmask;
                        ad = g1 ? req1_addr  : req0_addr;
                        wd = g1 ? req1_wdata : req0_wdata;
                        chk("acc_csb", sram_csb0, 0);
                        chk("acc_web", sram_web0, !we);
                        chk("acc_addr", sram_addr0, ad);
                        e.due = cyc + 2;
                        e.id  = g1;
                        if (we) begin
                            chk("acc_wmask", sram_wmask0, mk);
                            chk("acc_din", sram_din0, wd);
                            for (int b = 0; b < 4; b++)
                                if (mk[b]) m_mem[ad][8*b +: 8] = wd[8*b +: 8];
                            e.data = '0;
                        end else begin
                            e.data = m_mem[ad];
                        end
                        pq.push_back(e);
                        m_last = g1;
                    end else begin
                        chk("idle_csb", sram_csb0, 1);
                    end
                end
                rsp_check();
            end
        end
    end

    // Directed stimulus; each step drives one cycle and captures outputs mid-cycle.
    bit          cap_r0, cap_r1, cap_v0, cap_v1, cap_csb, cap_web;
    logic [31:0] cap_d0, cap_d1;
    logic [8:0]  cap_addr;
    int          n;
    bit          saw;
    logic [3:0]  pat_r0, pat_r1;
    logic [5:0]  pat_v0, pat_v1;

    task automatic step(input bit v0, input bit we0, input logic [3:0] m0,
                        input logic [8:0] a0, input logic [31:0] d0,
                        input bit v1, input bit we1, input logic [3:0] m1,
                        input logic [8:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_we = we0; req0_wmask = m0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_wmask = m1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        cap_r0 = req0_ready;  cap_r1 = req1_ready;
        cap_v0 = rsp0_valid;  cap_v1 = rsp1_valid;
        cap_d0 = rsp0_rdata;  cap_d1 = rsp1_rdata;
        cap_csb = sram_csb0;  cap_web = sram_web0; cap_addr = sram_addr0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 9'h0, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        chk("nc_ready0_in_reset", nc_req0_ready, 0);
        chk("nc_init_done_in_reset", nc_init_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First post-reset cycle: clear starts at 0, no-clear instance serves at once.
        @(negedge clk);
        chk("first_init_addr", sram_addr0, 0);
        chk("first_init_web", sram_web0, 0);
        chk("nc_first_ready0", nc_req0_ready, 1);
        chk("nc_first_init_done", nc_init_done, 1);
        chk("nc_first_csb", nc_sram_csb0, 0);
        n = 0;
        saw = 1'b0;
        while (init_done !== 1'b1 && n < 600) begin
            if (req0_ready || req1_ready) saw = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("init_cycles", n, 512);
        chk("init_no_ready", saw, 0);
        @(posedge clk);
        #1;

        // Read of the last address after clear.
        step(1, 0, 4'h0, 9'h1FF, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0);
        idle();
        idle();
        chk("rd1ff_valid", cap_v0, 1);
        chk("rd1ff_data", cap_d0, 32'h0000_0000);

        // req1 full write, partial write, read back.
        step(0, 0, 4'h0, 9'h0, 32'h0, 1, 1, 4'hF, 9'h010, 32'h1122_3344);
        step(0, 0, 4'h0, 9'h0, 32'h0, 1, 1, 4'h5, 9'h010, 32'hDEAD_BEEF);
        step(0, 0, 4'h0, 9'h0, 32'h0, 1, 0, 4'h0, 9'h010, 32'h0);
        idle();
        idle();
        chk("mask_rsp1_valid", cap_v1, 1);
        chk("mask_rsp1_data", cap_d1, 32'h11AD_33EF);
        chk("mask_rsp0_quiet", cap_v0, 0);

        // Both requesters valid for four cycles.
        pat_r0 = '0; pat_r1 = '0; pat_v0 = '0; pat_v1 = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1, 0, 4'h0, 9'h010, 32'h0, 1, 1, 4'hF, 9'h020, 32'h5555_0000 + i);
            else       idle();
            if (i < 4) begin
                pat_r0[i] = cap_r0;
                pat_r1[i] = cap_r1;
            end
            pat_v0[i] = cap_v0;
            pat_v1[i] = cap_v1;
        end
        chk("rr_grant0_pattern", pat_r0, 4'b0101);
        chk("rr_grant1_pattern", pat_r1, 4'b1010);
        chk("rr_rsp0_pattern", pat_v0, 6'b010100);
        chk("rr_rsp1_pattern", pat_v1, 6'b101000);

        // Write then immediate read of the same address.
        step(1, 1, 4'hF, 9'h0AA, 32'hCAFE_F00D, 0, 0, 4'h0, 9'h0, 32'h0);
        step(1, 0, 4'h0, 9'h0AA, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0);
        idle();
        chk("raw_wr_rsp_valid", cap_v0, 1);
        chk("raw_wr_rsp_data", cap_d0, 32'h0);
        idle();
        chk("raw_rd_rsp_valid", cap_v0, 1);
        chk("raw_rd_rsp_data", cap_d0, 32'hCAFE_F00D);

        // Reset one cycle after a read accept discards it and restarts the clear.
        step(1, 0, 4'h0, 9'h0AA, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0);
        chk("midrst_accept", cap_r0, 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        chk("midrst_no_rsp0", cap_v0, 0);
        chk("midrst_no_rsp1", cap_v1, 0);
        chk("midrst_init_csb", cap_csb, 0);
        chk("midrst_init_web", cap_web, 0);
        chk("midrst_init_addr", cap_addr, 0);
        idle();
        chk("midrst_init_addr1", cap_addr, 1);
        chk("midrst_late_rsp0", cap_v0, 0);

        n = 0;
        while (init_done !== 1'b1 && n < 600) begin
            idle();
            n++;
        end
        chk("reinit_done", init_done, 1);

        step(1, 0, 4'h0, 9'h0AA, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0);
        idle();
        idle();
        chk("reclear_rsp_valid", cap_v0, 1);
        chk("reclear_rsp_data", cap_d0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_port0_arbiter
`default_nettype wire
